cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, shall set the register, ALU and data-memory word width.
REQ-002 Parameter ADDR_W, default 16, shall set the data-memory address width.
REQ-003 Parameter PC_W, default 8, shall set the program counter and instruction-memory address width.
REQ-004 Parameter ACK_TIMEOUT, default 255, shall set the maximum number of cycles to wait for any memory ack.
REQ-005 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 Start  in  1  pulse that leaves IDLE and begins execution at PC=0.
REQ-008 Imem_req / Imem_addr / Imem_ack / Imem_rdata  out 1 / out PC_W / in 1 / in 32  instruction-fetch handshake.
REQ-009 Dmem_req / Dmem_we / Dmem_addr / Dmem_wdata  out 1 / out 1 / out ADDR_W / out DATA_W  data-access request.
REQ-010 Dmem_ack / Dmem_rdata  in 1 / in DATA_W  data-access completion and read data.
REQ-011 Alu_a / Alu_b / Alu_opcode / Alu_shift / Alu_imm  out DATA_W / DATA_W / 4 / 5 / 16  operands to the external combinational ALU.
REQ-012 Alu_result / Alu_flags  in DATA_W / 4  ALU result and new NZCV flags.
REQ-013 Pc / State / Flags / Halted / Err  out PC_W / 3 / 4 / 1 / 1  status outputs.

Function
REQ-014 The block shall hold a 16 x DATA_W register file, a 32-bit IR, a PC_W-bit PC and a 4-bit NZCV flag register.
REQ-015 IR decode shall be: Cond=[31:28], OpCode=[27:24], S=[23], Rd=[22:19], Rs2=[18:15], Rs1=[14:11], Shift=[10:6], Imm=[18:3].
REQ-016 FSM states shall be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7; State shall output the encoding.
REQ-017 IDLE->FETCH on Start=1; PC shall be cleared on that transition.
REQ-018 FETCH: assert Imem_req with Imem_addr=PC and hold both until Imem_ack=1; on ack, latch Imem_rdata into IR and go to DECODE.
REQ-019 DECODE: if OpCode=4'hF go to HALT; else if Cond fails, PC+=1 and go to FETCH; else go to EXEC.
REQ-020 Cond evaluation: 0000 EQ(Z), 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC, 1000 HI, 1001 LS, 1010 GE, 1011 LT, 1100 GT, 1101 LE, 1110 AL, 1111 never.
REQ-021 EXEC: Alu_a=R[Rs1], Alu_b=R[Rs2], Alu_opcode=OpCode, Alu_shift=Shift, Alu_imm=Imm driven combinationally from IR in every state.
REQ-022 EXEC for OpCode 4'h8 (LDR) or 4'h9 (STR) shall go to MEM; all other opcodes shall go to WB.
REQ-023 MEM: Dmem_addr=R[Rs1][ADDR_W-1:0], Dmem_we=1 for STR, Dmem_wdata=R[Rd]; Dmem_req held until Dmem_ack=1, then go to WB.
REQ-024 LDR shall latch Dmem_rdata on the ack cycle; STR shall write no register.
REQ-025 WB: ALU ops write Alu_result to R[Rd]; LDR writes loaded data to R[Rd]; when S=1 and op is ALU, Flags<=Alu_flags; then PC+=1 and go to FETCH.
REQ-026 Flags shall change only in WB with S=1 on a non-memory opcode.
REQ-027 PC shall wrap from 2^PC_W-1 to 0 without error.
REQ-028 A write to R[Rd] and a read of the same register in the same cycle shall return the old value.
REQ-029 An instruction shall take 4 cycles (ALU) or 5 cycles (LDR/STR) with zero-wait acks; each ack wait cycle adds one.
REQ-030 A wait cycle count reaching ACK_TIMEOUT in FETCH or MEM shall drop the request and enter ERR with Err=1.
REQ-031 HALT and ERR shall be sticky until Reset; Start shall be ignored outside IDLE.
REQ-032 Halted shall be 1 only in HALT; an ack arriving without an outstanding request shall be ignored.

Reset
REQ-033 Reset low shall immediately force State=IDLE, PC=0, IR=0, Flags=0, all registers 0, all req/we outputs 0, Halted=0, Err=0.
REQ-034 Reset asserted mid-handshake shall drop Imem_req/Dmem_req in the same cycle and commit no pending write.

Verification
REQ-035 Start, program R1=5,R2=3, ADD R3,R1,R2 with S=1, HALT -> R3=8, Flags=0000, Halted=1, PC at HALT address.
REQ-036 SUB S=1 giving zero, then NE-conditioned ADD -> ADD skipped, Rd unchanged, PC advances by 1, skip costs 2 cycles.
REQ-037 STR R4=32'hAAA5 to address 5, then LDR R6 from 5 with 3-cycle Dmem_ack delay -> R6=32'hAAA5, LDR takes 8 cycles.
REQ-038 Imem_ack held low for ACK_TIMEOUT cycles -> Imem_req drops, State=7, Err=1; Start ignored thereafter.
REQ-039 Reset pulsed low during MEM of an STR -> Dmem_req=0 immediately, State=0, registers 0, no later write issued.
REQ-040 PC_W=3 with 8 non-halting instructions -> PC wraps 7->0 and fetch continues at address 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches 32-bit instructions, evaluates the
// condition field against NZCV, drives an external combinational ALU and a
// data-memory handshake, and writes results back to a 16-entry register file.
module cpu_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned PC_W        = 8,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  output logic [4:0]        alu_shift,
  output logic [15:0]       alu_imm,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic [3:0]        flags,
  output logic              halted,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StErr    = 3'd7
  } state_e;

  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
  // Last wait count before a missing ack becomes an error.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   rf_q [16];
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic                cond_pass;

  // Instruction fields
  logic [3:0] ir_cond, ir_op, ir_rd, ir_rs2, ir_rs1;
  logic       ir_s;
  logic       is_load, is_store, is_mem;
  assign ir_cond  = ir_q[31:28];
  assign ir_op    = ir_q[27:24];
  assign ir_s     = ir_q[23];
  assign ir_rd    = ir_q[22:19];
  assign ir_rs2   = ir_q[18:15];
  assign ir_rs1   = ir_q[14:11];
  assign is_load  = (ir_op == 4'h8);
  assign is_store = (ir_op == 4'h9);
  assign is_mem   = is_load | is_store;

  // Bits [2:0] carry no field.
  logic ir_unused;
  assign ir_unused = ^ir_q[2:0];

  // ALU operands always reflect the current IR and register file.
  assign alu_a      = rf_q[ir_rs1];
  assign alu_b      = rf_q[ir_rs2];
  assign alu_opcode = ir_op;
  assign alu_shift  = ir_q[10:6];
  assign alu_imm    = ir_q[18:3];

  assign imem_req   = (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == StMem);
  assign dmem_we    = (state_q == StMem) && is_store;
  assign dmem_addr  = rf_q[ir_rs1][ADDR_W-1:0];
  assign dmem_wdata = rf_q[ir_rd];

  assign pc     = pc_q;
  assign state  = state_q;
  assign flags  = flags_q;
  assign halted = (state_q == StHalt);
  assign err    = (state_q == StErr);

  // Condition code check against NZCV = flags_q[3:0].
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_pass = 1'b0;
    case (ir_cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Next-state, architectural updates and register-file write request.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    mdr_d    = mdr_q;
    wait_d   = '0;
    rf_we    = 1'b0;
    rf_wdata = alu_result;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end else if (wait_q == WAIT_LAST) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StDecode: begin
        if (ir_op == 4'hF) begin
          state_d = StHalt;
        end else if (!cond_pass) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: state_d = is_mem ? StMem : StWb;
      StMem: begin
        if (dmem_ack) begin
          if (is_load) mdr_d = dmem_rdata;
          state_d = StWb;
        end else if (wait_q == WAIT_LAST) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StWb: begin
        if (!is_store) begin
          rf_we    = 1'b1;
          rf_wdata = is_load ? mdr_q : alu_result;
        end
        if (ir_s && !is_mem) flags_d = alu_flags;
        pc_d    = pc_q + PC_W'(1);
        state_d = StFetch;
      end
      default: ; // StHalt and StErr hold until reset
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      mdr_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      mdr_q   <= mdr_d;
      wait_q  <= wait_d;
    end
  end

  // Register file; reads see the pre-write value during a write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[ir_rd] <= rf_wdata;
    end
  end

endmodule
